// File: rtl/spi_frame_receiver_if.sv
// SPI pin bundle plus the word-level handshake toward the interface controller.
// The slave modport is the receiver's view; master is the external SPI master/controller side.
interface spi_frame_receiver_if #(
  parameter int WIDTH = 16
);
  logic             sclk;
  logic             mosi;
  logic             csN;
  logic             miso;
  logic [WIDTH-1:0] outgoingData;
  logic [WIDTH-1:0] spi;
  logic             readBusy;
  logic             writeBusy;
  logic             frameError;

  modport slave (
    input  sclk, mosi, csN, outgoingData,
    output miso, spi, readBusy, writeBusy, frameError
  );

  modport master (
    output sclk, mosi, csN, outgoingData,
    input  miso, spi, readBusy, writeBusy, frameError
  );
endinterface

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave front-end: synchronises the SPI pins into the clk domain,
// deserialises WIDTH-bit frames MSB first and shifts outgoingData out on MISO.
module spi_frame_receiver #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  spi_frame_receiver_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic [SYNC_STAGES-1:0] r_csNSync;
  logic                   r_sclkPrev;
  logic                   r_csNPrev;

  logic [WIDTH-1:0] r_rx;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_spi;
  logic [CNT_W-1:0] r_bitCount;
  logic             r_miso;
  logic             r_frameError;

  logic w_sclk;
  logic w_mosi;
  logic w_csN;
  logic w_sclkRise;
  logic w_sclkFall;
  logic w_csFall;
  logic w_csRise;
  logic w_busy;

  // Prev copies reset to 0 so a CS_N held low through reset never looks like a falling edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclkSync <= '0;
      r_mosiSync <= '0;
      r_csNSync  <= '0;
      r_sclkPrev <= 1'b0;
      r_csNPrev  <= 1'b0;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], bus.sclk};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], bus.mosi};
      r_csNSync  <= {r_csNSync[SYNC_STAGES-2:0], bus.csN};
      r_sclkPrev <= r_sclkSync[SYNC_STAGES-1];
      r_csNPrev  <= r_csNSync[SYNC_STAGES-1];
    end
  end

  assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
  assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
  assign w_csN      = r_csNSync[SYNC_STAGES-1];
  assign w_sclkRise = w_sclk & ~r_sclkPrev;
  assign w_sclkFall = ~w_sclk & r_sclkPrev;
  assign w_csFall   = ~w_csN & r_csNPrev;
  assign w_csRise   = w_csN & ~r_csNPrev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_csFall) w_stateNext = ACTIVE;
      ACTIVE:  if (w_csRise) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    if (r_state == ACTIVE) begin
      w_busy = 1'b1;
    end
  end

  // CS_N rising takes priority over any SCLK edge detected in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx         <= '0;
      r_tx         <= '0;
      r_spi        <= '0;
      r_bitCount   <= '0;
      r_miso       <= 1'b0;
      r_frameError <= 1'b0;
    end else begin
      r_frameError <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_csFall) begin
            r_tx       <= bus.outgoingData;
            r_bitCount <= '0;
            r_miso     <= bus.outgoingData[WIDTH-1];
          end
        end
        ACTIVE: begin
          if (w_csRise) begin
            if (r_bitCount == CNT_FULL) begin
              r_spi <= r_rx;
            end else begin
              r_frameError <= 1'b1;
            end
            r_miso <= 1'b0;
          end else if (w_sclkRise) begin
            r_rx <= {r_rx[WIDTH-2:0], w_mosi};
            if (r_bitCount != CNT_SAT) begin
              r_bitCount <= r_bitCount + CNT_W'(1);
            end
          end else if (w_sclkFall) begin
            r_tx   <= {r_tx[WIDTH-2:0], 1'b0};
            r_miso <= r_tx[WIDTH-2];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.miso       = r_miso;
  assign bus.spi        = r_spi;
  assign bus.readBusy   = w_busy;
  assign bus.writeBusy  = w_busy;
  assign bus.frameError = r_frameError;
endmodule

// File: tb/tb_spi_frame_receiver.sv
// Drives spi_frame_receiver as an SPI master and checks it against a frame-level model:
// a frame commits only when exactly WIDTH bits were clocked, otherwise it raises one error pulse.
module tb_spi_frame_receiver;
  localparam int WIDTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int vectors      = 0;
  int miscompares  = 0;
  int errPulses    = 0;
  int expErrPulses = 0;
  logic [WIDTH-1:0] expSpi;

  always #5 clock = ~clock;

  spi_frame_receiver_if #(.WIDTH(WIDTH)) bus ();

  spi_frame_receiver #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk(clock),
    .i_rst(reset),
    .bus  (bus.slave)
  );

  always @(posedge clock) begin
    if (!reset && bus.frameError === 1'b1) errPulses++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One master transaction; csN is left high for 4 + gap cycles afterwards.
  task automatic applyStimulus(input logic [31:0] data, input int nBits, input logic [15:0] txWord,
                               input int changeBit, input logic [15:0] midTx, input int gap);
    logic [15:0] misoWord;
    misoWord = '0;
    bus.outgoingData = txWord;
    bus.csN = 1'b0;
    waitCycles(2);
    checkOutput("readBusy_before_latency", {31'd0, bus.readBusy}, 32'd0);
    waitCycles(1);
    checkOutput("readBusy_start", {31'd0, bus.readBusy}, 32'd1);
    checkOutput("writeBusy_start", {31'd0, bus.writeBusy}, 32'd1);
    for (int i = 0; i < nBits; i++) begin
      if (i == changeBit) bus.outgoingData = midTx;
      bus.mosi = data[nBits-1-i];
      waitCycles(4);
      bus.sclk = 1'b1;
      misoWord = {misoWord[14:0], bus.miso};
      waitCycles(4);
      bus.sclk = 1'b0;
    end
    waitCycles(4);
    bus.csN = 1'b1;
    if (nBits == WIDTH) begin
      expSpi = data[15:0];
      checkOutput("miso_stream", {16'd0, misoWord}, {16'd0, txWord});
    end else begin
      expErrPulses++;
    end
    waitCycles(2);
    checkOutput("readBusy_before_commit", {31'd0, bus.readBusy}, 32'd1);
    waitCycles(1);
    checkOutput("readBusy_end", {31'd0, bus.readBusy}, 32'd0);
    checkOutput("writeBusy_end", {31'd0, bus.writeBusy}, 32'd0);
    checkOutput("spi_word", {16'd0, bus.spi}, {16'd0, expSpi});
    checkOutput("frameError_pulse", {31'd0, bus.frameError}, {31'd0, (nBits != WIDTH)});
    checkOutput("miso_idle", {31'd0, bus.miso}, 32'd0);
    waitCycles(1);
    checkOutput("frameError_cleared", {31'd0, bus.frameError}, 32'd0);
    if (gap > 0) waitCycles(gap);
  endtask

  initial begin
    int nBits;
    int sel;
    logic [31:0] data;
    logic [15:0] tx;

    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.csN  = 1'b1;
    bus.outgoingData = '0;
    expSpi = '0;

    reset = 1'b1;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(1);
    checkOutput("reset_spi", {16'd0, bus.spi}, 32'd0);
    checkOutput("reset_readBusy", {31'd0, bus.readBusy}, 32'd0);
    checkOutput("reset_writeBusy", {31'd0, bus.writeBusy}, 32'd0);
    checkOutput("reset_miso", {31'd0, bus.miso}, 32'd0);
    checkOutput("reset_frameError", {31'd0, bus.frameError}, 32'd0);
    waitCycles(5);
    checkOutput("idle_after_reset", {31'd0, bus.readBusy}, 32'd0);

    // Good frame
    applyStimulus(32'h2343, 16, 16'h0343, -1, 16'h0000, 3);

    // outgoingData changed mid-frame is not seen until the next frame
    applyStimulus(32'h1A5C, 16, 16'h0343, 5, 16'h0FFF, 3);
    applyStimulus(32'h7E81, 16, 16'h0FFF, -1, 16'h0000, 3);

    // Short and long frames are discarded
    applyStimulus(32'h3343, 16, 16'h0343, -1, 16'h0000, 3);
    applyStimulus(32'h0ABC, 12, 16'h0343, -1, 16'h0000, 3);
    applyStimulus(32'h1_5A5A, 17, 16'h0343, -1, 16'h0000, 3);

    // Reset in the middle of a frame
    applyStimulus(32'h4343, 16, 16'h0343, -1, 16'h0000, 3);
    bus.outgoingData = 16'hBEEF;
    bus.csN = 1'b0;
    waitCycles(3);
    for (int i = 0; i < 8; i++) begin
      bus.mosi = i[0];
      waitCycles(4);
      bus.sclk = 1'b1;
      waitCycles(4);
      bus.sclk = 1'b0;
    end
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    expSpi = '0;
    waitCycles(1);
    checkOutput("midreset_spi", {16'd0, bus.spi}, 32'd0);
    checkOutput("midreset_readBusy", {31'd0, bus.readBusy}, 32'd0);
    checkOutput("midreset_writeBusy", {31'd0, bus.writeBusy}, 32'd0);
    checkOutput("midreset_miso", {31'd0, bus.miso}, 32'd0);
    checkOutput("midreset_frameError", {31'd0, bus.frameError}, 32'd0);
    waitCycles(6);
    checkOutput("csN_low_after_reset_no_frame", {31'd0, bus.readBusy}, 32'd0);
    bus.csN = 1'b1;
    waitCycles(6);
    applyStimulus(32'h5342, 16, 16'h0343, -1, 16'h0000, 3);

    // Back-to-back frames with the minimum CS_N high gap
    applyStimulus(32'h4343, 16, 16'h0343, -1, 16'h0000, 0);
    applyStimulus(32'h6343, 16, 16'h0343, -1, 16'h0000, 3);

    // Randomised frames of 15, 16 or 17 bits
    for (int k = 0; k < 8; k++) begin
      sel = int'($urandom_range(0, 4));
      nBits = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
      data = $urandom & ((32'h1 << nBits) - 32'h1);
      tx = 16'($urandom);
      applyStimulus(data, nBits, tx, -1, 16'h0000, int'($urandom_range(0, 5)));
    end

    waitCycles(2);
    checkOutput("frameError_total", errPulses, expErrPulses);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Upstream SPI slave front-end for the interface controller. Synchronises the external SPI master's SCLK, MOSI and CS_N into the CLK domain and deserialises 16-bit frames, MSB first, in SPI mode 0. Each complete frame is presented as a 16-bit word, {4-bit address, 12-bit data}, on `spi`. The block also shifts `outgoingData` out on MISO during the same frame. `readBusy` and `writeBusy` tell the interface controller when `spi` is unstable and when `outgoingData` is being captured.

## Interface
- `WIDTH`, default 16: frame length in bits.
- `SYNC_STAGES`, default 2: synchroniser flops per SPI input (minimum 2).
- `CLK` in 1: system clock. All logic is clocked on the rising edge.
- `RST` in 1: reset. Synchronous, active-high.
- `SCLK` in 1: SPI clock from the master. Asynchronous to `CLK`.
- `MOSI` in 1: serial data from the master.
- `CS_N` in 1: chip select, active low.
- `MISO` out 1: serial data to the master.
- `outgoingData` in WIDTH: word to transmit. Sampled at frame start.
- `spi` out WIDTH: last good received frame.
- `readBusy` out 1: high while a frame is in progress, so `spi` must not be consumed.
- `writeBusy` out 1: high while a frame is in progress, so `outgoingData` must stay stable.
- `frameError` out 1: one-cycle pulse when a frame is discarded.

## Operation
- **Synchronisers:** SCLK, MOSI and CS_N each pass through SYNC_STAGES flops.
  - Edge detectors compare the last sync stage with one further registered copy.
  - All "prev" and sync flops reset to 0. As a result, CS_N held low through reset produces no falling edge, and no frame starts until CS_N has gone high and then low again.
- **FSM states:**
  - **IDLE:**
    - On a synchronised CS_N falling edge, go to ACTIVE.
    - In the same edge: load the tx shift register from `outgoingData`, clear the bit count, and set `readBusy`, `writeBusy` and `MISO` = `outgoingData[WIDTH-1]`.
  - **ACTIVE, per SCLK rising edge:** shift the synchronised MOSI into the LSB of the rx shift register and increment the bit count. The count saturates at WIDTH+1.
  - **ACTIVE, per SCLK falling edge:** shift the tx register left and drive the new MSB onto MISO. Shift in 0.
  - **ACTIVE, on a CS_N rising edge:**
    - If the bit count is exactly WIDTH: `spi` <= rx shift register.
    - Otherwise: `spi` is unchanged and `frameError` pulses for 1 cycle.
    - In both cases, go to IDLE and clear `readBusy`, `writeBusy` and `MISO` in the same edge.
- SCLK edges seen in IDLE are ignored. A CS_N rising edge seen in IDLE is ignored.
- **Simultaneous events:**
  - If a CS_N rising edge coincides with an SCLK edge in the same cycle, CS_N takes priority and the SCLK edge is dropped.
  - A CS_N falling edge arriving in the cycle the FSM returns to IDLE is lost. The master must respect the minimum gap given under Timing.

## Timing
- **Reset values:** `spi` = 0, `readBusy` = 0, `writeBusy` = 0, `MISO` = 0, `frameError` = 0, state IDLE, counters and shift registers 0.
- **Reset mid-frame:** the frame is aborted, `spi` returns to 0, and no `frameError` is generated.
- **Latency:** outputs react on the (SYNC_STAGES+1)th CLK rising edge after a pin transition, within ±1 cycle of synchroniser uncertainty.
  - For SYNC_STAGES = 2, CS_N falling to `readBusy` high takes 3 CLK.
  - For SYNC_STAGES = 2, CS_N rising to `spi` valid with `readBusy` low takes 3 CLK.
- **Commit handshake:** `spi` and the `readBusy` falling edge update in the same CLK edge. The consumer may sample `spi` on any edge where `readBusy` = 0.
- **MISO validity:** MISO changes (SYNC_STAGES+1) CLK after each SCLK falling edge. It is stable before the next SCLK rising edge provided f_CLK ≥ 8·f_SCLK.
- **Master constraints:**
  - CS_N high for at least 4 CLK between frames.
  - SCLK high and low phases each at least 3 CLK.
  - SCLK idle low while CS_N is high.

## Test plan
- **Good frame:** master sends 0x2343 (16 clocks), `outgoingData` = 0x0343.
  - `readBusy` and `writeBusy` go high 3 CLK after CS_N falls.
  - MISO bit stream equals 0x0343.
  - 3 CLK after CS_N rises, `spi` = 0x2343 and `readBusy` = 0.
- **Capture at frame start:** change `outgoingData` from 0x0343 to 0x0FFF mid-frame.
  - MISO still returns 0x0343.
  - The next frame returns 0x0FFF.
- **Short frame:** after a good 0x3343 frame, send 12 clocks of 0xABC.
  - `frameError` pulses once.
  - `spi` stays 0x3343.
  - `readBusy` falls.
- **Long frame:** send 17 clocks.
  - `frameError` pulses once.
  - `spi` is unchanged.
- **Reset mid-frame:** after a good 0x4343 frame, start a frame and assert RST after 8 clocks.
  - All outputs return to their reset values.
  - CS_N still low after reset starts no frame.
  - After CS_N goes high and then low, the frame 0x5342 is received correctly.
- **Back-to-back frames:** send 0x4343 and then 0x6343 with a 4-CLK CS_N gap.
  - `spi` shows 0x4343 and then 0x6343.
  - No `frameError`.
